// File: rtl/cam_chan_ctrl_if.sv
// Camera channel control bundle: raw keys, per-channel vsync and mode in; applied enables and status out.
interface cam_chan_ctrl_if #(
    parameter int CH_NUM = 2
);
    logic [CH_NUM-1:0] key_in;
    logic [CH_NUM-1:0] cam_vsync;
    logic [1:0]        mode;
    logic [CH_NUM-1:0] ch_en;
    logic [CH_NUM-1:0] ch_pend;
    logic [CH_NUM-1:0] key_flag;
    logic [2:0]        active_ch;

    modport master (
        output key_in, cam_vsync, mode,
        input  ch_en, ch_pend, key_flag, active_ch
    );

    modport slave (
        input  key_in, cam_vsync, mode,
        output ch_en, ch_pend, key_flag, active_ch
    );
endinterface

// File: rtl/cam_chan_ctrl.sv
// Per-channel camera write enables: debounced keys steer a target mask that each channel adopts at its own frame start.
// Inputs pass three register stages; ch_en follows vs_rise by one cycle, ch_pend/active_ch one more; no backpressure.
module cam_chan_ctrl #(
    parameter int                CH_NUM        = 2,
    parameter int                CNT_MAX       = 999_999,
    parameter logic [CH_NUM-1:0] INIT_EN       = {CH_NUM{1'b1}},
    parameter logic [7:0]        FRAMES_PER_CH = 8'd30,
    parameter logic [23:0]       VS_TIMEOUT    = 24'd5_000_000
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    cam_chan_ctrl_if.slave  io_bus
);
    localparam int               CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_FIRE   = CNT_W'(CNT_MAX - 1);
    localparam logic [23:0]      WAIT_LAST  = VS_TIMEOUT - 24'd1;
    localparam logic [7:0]       FRAME_LAST = FRAMES_PER_CH - 8'd1;
    localparam logic [1:0]       MODE_TOGGLE = 2'd0;
    localparam logic [1:0]       MODE_EXCL   = 2'd1;
    localparam logic [1:0]       MODE_AUTO   = 2'd2;

    function automatic logic [2:0] lowest_idx(input logic [CH_NUM-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [CH_NUM-1:0] one_hot(input logic [2:0] idx);
        logic [CH_NUM-1:0] v;
        v = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            v[i] = (idx == 3'(i));
        end
        return v;
    endfunction

    logic [CH_NUM-1:0] r_key_s1, r_key_s2, r_key_s3;
    logic [CH_NUM-1:0] r_vs_s1, r_vs_s2, r_vs_s3;
    logic [CNT_W-1:0]  r_cnt [CH_NUM];
    logic [CH_NUM-1:0] r_key_flag;
    logic [1:0]        r_mode, r_mode_prev;
    logic [CH_NUM-1:0] r_target, r_ch_en, r_pend;
    logic [7:0]        r_frame_cnt;
    logic [2:0]        r_active_ch;
    logic [23:0]       r_wait [CH_NUM];

    logic [CH_NUM-1:0] w_vs_rise;
    logic [CH_NUM-1:0] w_force;
    logic [CH_NUM-1:0] w_apply;
    logic [1:0]        w_mode_in;
    logic              w_mode_chg;
    logic              w_vs_active;
    logic [2:0]        w_next_ch;
    logic [CH_NUM-1:0] w_target_nxt;
    logic [7:0]        w_frame_nxt;

    // Keys idle high, so their synchronisers reset high to avoid a phantom press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_key_s1 <= '1;
            r_key_s2 <= '1;
            r_key_s3 <= '1;
            r_vs_s1  <= '0;
            r_vs_s2  <= '0;
            r_vs_s3  <= '0;
        end else begin
            r_key_s1 <= io_bus.key_in;
            r_key_s2 <= r_key_s1;
            r_key_s3 <= r_key_s2;
            r_vs_s1  <= io_bus.cam_vsync;
            r_vs_s2  <= r_vs_s1;
            r_vs_s3  <= r_vs_s2;
        end
    end

    assign w_vs_rise = r_vs_s2 & ~r_vs_s3;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < CH_NUM; i++) r_cnt[i] <= '0;
            r_key_flag <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (r_key_s3[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] != CNT_TOP) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
                r_key_flag[i] <= ~r_key_s3[i] && (r_cnt[i] == CNT_FIRE);
            end
        end
    end

    assign w_mode_in   = (io_bus.mode == 2'd3) ? MODE_TOGGLE : io_bus.mode;
    assign w_mode_chg  = (r_mode != r_mode_prev);
    assign w_vs_active = |(w_vs_rise & one_hot(r_active_ch));
    assign w_next_ch   = (r_active_ch == 3'(CH_NUM - 1)) ? 3'd0 : r_active_ch + 3'd1;

    always_comb begin
        w_target_nxt = r_target;
        w_frame_nxt  = r_frame_cnt;
        if (w_mode_chg) begin
            // Keys are dropped on the switch cycle; the new mode starts from what is really enabled.
            if (r_mode == MODE_TOGGLE) begin
                w_target_nxt = r_ch_en;
            end else begin
                w_target_nxt = one_hot(lowest_idx(r_ch_en));
                w_frame_nxt  = 8'd0;
            end
        end else begin
            case (r_mode)
                MODE_EXCL: begin
                    if (|r_key_flag) w_target_nxt = one_hot(lowest_idx(r_key_flag));
                end
                MODE_AUTO: begin
                    if (|r_key_flag) begin
                        w_target_nxt = one_hot(lowest_idx(r_key_flag));
                        w_frame_nxt  = 8'd0;
                    end else if (w_vs_active) begin
                        if (r_frame_cnt == FRAME_LAST) begin
                            w_target_nxt = one_hot(w_next_ch);
                            w_frame_nxt  = 8'd0;
                        end else begin
                            w_frame_nxt = r_frame_cnt + 8'd1;
                        end
                    end
                end
                default: w_target_nxt = r_target ^ r_key_flag;
            endcase
        end
    end

    always_comb begin
        w_force = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            w_force[i] = r_pend[i] && (r_wait[i] == WAIT_LAST);
        end
    end

    assign w_apply = w_vs_rise | w_force;

    // Apply uses the target held before this cycle's update, so a key coinciding with vsync waits a frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode      <= MODE_TOGGLE;
            r_mode_prev <= MODE_TOGGLE;
            r_target    <= INIT_EN;
            r_ch_en     <= INIT_EN;
            r_pend      <= '0;
            r_frame_cnt <= 8'd0;
            r_active_ch <= lowest_idx(INIT_EN);
            for (int i = 0; i < CH_NUM; i++) r_wait[i] <= '0;
        end else begin
            r_mode      <= w_mode_in;
            r_mode_prev <= r_mode;
            r_target    <= w_target_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_ch_en     <= (r_ch_en & ~w_apply) | (r_target & w_apply);
            r_pend      <= r_target ^ r_ch_en;
            r_active_ch <= (r_mode == MODE_TOGGLE) ? lowest_idx(r_ch_en) : lowest_idx(r_target);
            for (int i = 0; i < CH_NUM; i++) begin
                if (!r_pend[i] || w_apply[i]) begin
                    r_wait[i] <= '0;
                end else begin
                    r_wait[i] <= r_wait[i] + 24'd1;
                end
            end
        end
    end

    assign io_bus.ch_en     = r_ch_en;
    assign io_bus.ch_pend   = r_pend;
    assign io_bus.key_flag  = r_key_flag;
    assign io_bus.active_ch = r_active_ch;

endmodule

// File: tb/tb_cam_chan_ctrl.sv
// Directed bench for cam_chan_ctrl with CH_NUM=2, CNT_MAX=4, VS_TIMEOUT=100, FRAMES_PER_CH=2.
module tb_cam_chan_ctrl;
    logic sys_clk;
    logic sys_rst_n;
    int   n_tests;
    int   n_fail;

    cam_chan_ctrl_if #(.CH_NUM(2)) cc_bus ();

    cam_chan_ctrl #(
        .CH_NUM        (2),
        .CNT_MAX       (4),
        .INIT_EN       (2'b11),
        .FRAMES_PER_CH (8'd2),
        .VS_TIMEOUT    (24'd100)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .io_bus    (cc_bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Holds the keys in m low for n cycles, releases, and counts cycles where key_flag equals m.
    task automatic press(input logic [1:0] m, input int n, output int pulses);
        pulses = 0;
        cc_bus.key_in = ~m;
        repeat (n) begin
            @(negedge sys_clk);
            if (cc_bus.key_flag == m) pulses++;
        end
        cc_bus.key_in = 2'b11;
        repeat (8) begin
            @(negedge sys_clk);
            if (cc_bus.key_flag == m) pulses++;
        end
    endtask

    task automatic vs_pulse(input int ch);
        cc_bus.cam_vsync[ch] = 1'b1;
        cyc(6);
        cc_bus.cam_vsync[ch] = 1'b0;
        cyc(6);
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        cc_bus.key_in = 2'b11;
        cc_bus.cam_vsync = 2'b00;
        cc_bus.mode = 2'd0;
        cyc(3);
        sys_rst_n = 1'b1;
        cyc(3);
        n_tests++; if (cc_bus.ch_en !== 2'b11) begin n_fail++; $display("FAIL rst_ch_en: got %b want 11", cc_bus.ch_en); end
        n_tests++; if (cc_bus.ch_pend !== 2'b00) begin n_fail++; $display("FAIL rst_ch_pend: got %b want 00", cc_bus.ch_pend); end
        n_tests++; if (cc_bus.key_flag !== 2'b00) begin n_fail++; $display("FAIL rst_key_flag: got %b want 00", cc_bus.key_flag); end
        n_tests++; if (cc_bus.active_ch !== 3'd0) begin n_fail++; $display("FAIL rst_active: got %0d want 0", cc_bus.active_ch); end
    endtask

    task automatic test_toggle;
        int p;
        press(2'b01, 10, p);
        n_tests++; if (p != 1) begin n_fail++; $display("FAIL tog_pulses: got %0d want 1", p); end
        n_tests++; if (cc_bus.ch_pend !== 2'b01) begin n_fail++; $display("FAIL tog_pend: got %b want 01", cc_bus.ch_pend); end
        vs_pulse(1);
        n_tests++; if (cc_bus.ch_en !== 2'b11) begin n_fail++; $display("FAIL tog_vs1_ch_en: got %b want 11", cc_bus.ch_en); end
        vs_pulse(0);
        n_tests++; if (cc_bus.ch_en !== 2'b10) begin n_fail++; $display("FAIL tog_vs0_ch_en: got %b want 10", cc_bus.ch_en); end
        n_tests++; if (cc_bus.ch_pend !== 2'b00) begin n_fail++; $display("FAIL tog_vs0_pend: got %b want 00", cc_bus.ch_pend); end
        n_tests++; if (cc_bus.active_ch !== 3'd1) begin n_fail++; $display("FAIL tog_active: got %0d want 1", cc_bus.active_ch); end
    endtask

    task automatic test_debounce;
        int p;
        press(2'b01, 3, p);
        n_tests++; if (p != 0) begin n_fail++; $display("FAIL db_short_pulses: got %0d want 0", p); end
        n_tests++; if (cc_bus.ch_pend !== 2'b00) begin n_fail++; $display("FAIL db_short_pend: got %b want 00", cc_bus.ch_pend); end
        press(2'b01, 50, p);
        n_tests++; if (p != 1) begin n_fail++; $display("FAIL db_long_pulses: got %0d want 1", p); end
        n_tests++; if (cc_bus.ch_pend !== 2'b01) begin n_fail++; $display("FAIL db_long_pend: got %b want 01", cc_bus.ch_pend); end
        vs_pulse(0);
        n_tests++; if (cc_bus.ch_en !== 2'b11) begin n_fail++; $display("FAIL db_ch_en: got %b want 11", cc_bus.ch_en); end
    endtask

    // Vsync is raised so its synchronised rise lands in the same cycle as the key_flag pulse.
    task automatic test_same_cycle;
        int p;
        p = 0;
        cc_bus.key_in = 2'b10;
        repeat (5) begin @(negedge sys_clk); if (cc_bus.key_flag == 2'b01) p++; end
        cc_bus.cam_vsync[0] = 1'b1;
        repeat (8) begin @(negedge sys_clk); if (cc_bus.key_flag == 2'b01) p++; end
        cc_bus.key_in = 2'b11;
        cc_bus.cam_vsync[0] = 1'b0;
        repeat (8) begin @(negedge sys_clk); if (cc_bus.key_flag == 2'b01) p++; end
        n_tests++; if (p != 1) begin n_fail++; $display("FAIL sc_pulses: got %0d want 1", p); end
        n_tests++; if (cc_bus.ch_en !== 2'b11) begin n_fail++; $display("FAIL sc_ch_en_hold: got %b want 11", cc_bus.ch_en); end
        n_tests++; if (cc_bus.ch_pend !== 2'b01) begin n_fail++; $display("FAIL sc_pend: got %b want 01", cc_bus.ch_pend); end
        vs_pulse(0);
        n_tests++; if (cc_bus.ch_en !== 2'b10) begin n_fail++; $display("FAIL sc_ch_en_next: got %b want 10", cc_bus.ch_en); end
    endtask

    task automatic test_exclusive;
        int p;
        press(2'b01, 10, p);
        vs_pulse(0);
        n_tests++; if (cc_bus.ch_en !== 2'b11) begin n_fail++; $display("FAIL ex_start_ch_en: got %b want 11", cc_bus.ch_en); end
        cc_bus.mode = 2'd1;
        cyc(6);
        n_tests++; if (cc_bus.ch_pend !== 2'b10) begin n_fail++; $display("FAIL ex_switch_pend: got %b want 10", cc_bus.ch_pend); end
        n_tests++; if (cc_bus.active_ch !== 3'd0) begin n_fail++; $display("FAIL ex_switch_active: got %0d want 0", cc_bus.active_ch); end
        press(2'b10, 10, p);
        n_tests++; if (cc_bus.ch_pend !== 2'b01) begin n_fail++; $display("FAIL ex_key1_pend: got %b want 01", cc_bus.ch_pend); end
        n_tests++; if (cc_bus.active_ch !== 3'd1) begin n_fail++; $display("FAIL ex_key1_active: got %0d want 1", cc_bus.active_ch); end
        vs_pulse(0);
        n_tests++; if (cc_bus.ch_en !== 2'b10) begin n_fail++; $display("FAIL ex_vs0_ch_en: got %b want 10", cc_bus.ch_en); end
        vs_pulse(1);
        n_tests++; if (cc_bus.ch_en !== 2'b10) begin n_fail++; $display("FAIL ex_vs1_ch_en: got %b want 10", cc_bus.ch_en); end
        press(2'b11, 10, p);
        n_tests++; if (p != 1) begin n_fail++; $display("FAIL ex_both_pulses: got %0d want 1", p); end
        n_tests++; if (cc_bus.ch_pend !== 2'b11) begin n_fail++; $display("FAIL ex_both_pend: got %b want 11", cc_bus.ch_pend); end
        n_tests++; if (cc_bus.active_ch !== 3'd0) begin n_fail++; $display("FAIL ex_both_active: got %0d want 0", cc_bus.active_ch); end
        vs_pulse(0);
        vs_pulse(1);
        n_tests++; if (cc_bus.ch_en !== 2'b01) begin n_fail++; $display("FAIL ex_end_ch_en: got %b want 01", cc_bus.ch_en); end
    endtask

    task automatic test_auto_cycle;
        cc_bus.mode = 2'd2;
        cyc(6);
        n_tests++; if (cc_bus.ch_pend !== 2'b00) begin n_fail++; $display("FAIL ac_switch_pend: got %b want 00", cc_bus.ch_pend); end
        vs_pulse(0);
        n_tests++; if (cc_bus.active_ch !== 3'd0) begin n_fail++; $display("FAIL ac_f1_active: got %0d want 0", cc_bus.active_ch); end
        n_tests++; if (cc_bus.ch_pend !== 2'b00) begin n_fail++; $display("FAIL ac_f1_pend: got %b want 00", cc_bus.ch_pend); end
        vs_pulse(0);
        n_tests++; if (cc_bus.active_ch !== 3'd1) begin n_fail++; $display("FAIL ac_f2_active: got %0d want 1", cc_bus.active_ch); end
        n_tests++; if (cc_bus.ch_pend !== 2'b11) begin n_fail++; $display("FAIL ac_f2_pend: got %b want 11", cc_bus.ch_pend); end
        n_tests++; if (cc_bus.ch_en !== 2'b01) begin n_fail++; $display("FAIL ac_f2_ch_en: got %b want 01", cc_bus.ch_en); end
        vs_pulse(1);
        n_tests++; if (cc_bus.ch_en !== 2'b11) begin n_fail++; $display("FAIL ac_vs1_ch_en: got %b want 11", cc_bus.ch_en); end
        vs_pulse(0);
        n_tests++; if (cc_bus.ch_en !== 2'b10) begin n_fail++; $display("FAIL ac_vs0_ch_en: got %b want 10", cc_bus.ch_en); end
        n_tests++; if (cc_bus.ch_pend !== 2'b00) begin n_fail++; $display("FAIL ac_vs0_pend: got %b want 00", cc_bus.ch_pend); end
    endtask

    task automatic test_timeout;
        int k;
        int n;
        int p;
        cc_bus.mode = 2'd0;
        cyc(6);
        n_tests++; if (cc_bus.ch_pend !== 2'b00) begin n_fail++; $display("FAIL to_switch_pend: got %b want 00", cc_bus.ch_pend); end
        cc_bus.key_in = 2'b10;
        k = 0;
        while (cc_bus.ch_pend[0] !== 1'b1 && k < 40) begin @(negedge sys_clk); k++; end
        cc_bus.key_in = 2'b11;
        n = 0;
        while (cc_bus.ch_en[0] !== 1'b1 && n < 300) begin @(negedge sys_clk); n++; end
        n_tests++; if (n != 100) begin n_fail++; $display("FAIL to_delay: got %0d cycles want 100", n); end
        cyc(3);
        n_tests++; if (cc_bus.ch_en !== 2'b11) begin n_fail++; $display("FAIL to_ch_en: got %b want 11", cc_bus.ch_en); end
        n_tests++; if (cc_bus.ch_pend !== 2'b00) begin n_fail++; $display("FAIL to_pend: got %b want 00", cc_bus.ch_pend); end
        press(2'b10, 10, p);
        n_tests++; if (cc_bus.ch_pend !== 2'b10) begin n_fail++; $display("FAIL to_wait_pend: got %b want 10", cc_bus.ch_pend); end
        cyc(20);
        cc_bus.key_in = 2'b10;
        cyc(2);
        sys_rst_n = 1'b0;
        #1;
        n_tests++; if (cc_bus.ch_en !== 2'b11) begin n_fail++; $display("FAIL rr_ch_en: got %b want 11", cc_bus.ch_en); end
        n_tests++; if (cc_bus.ch_pend !== 2'b00) begin n_fail++; $display("FAIL rr_pend: got %b want 00", cc_bus.ch_pend); end
        cyc(2);
        cc_bus.key_in = 2'b11;
        cyc(2);
        sys_rst_n = 1'b1;
        p = 0;
        repeat (20) begin @(negedge sys_clk); if (cc_bus.key_flag != 2'b00) p++; end
        n_tests++; if (p != 0) begin n_fail++; $display("FAIL rr_no_flag: got %0d pulses want 0", p); end
        n_tests++; if (cc_bus.ch_en !== 2'b11) begin n_fail++; $display("FAIL rr_post_ch_en: got %b want 11", cc_bus.ch_en); end
        n_tests++; if (cc_bus.ch_pend !== 2'b00) begin n_fail++; $display("FAIL rr_post_pend: got %b want 00", cc_bus.ch_pend); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset;
        test_toggle;
        test_debounce;
        test_same_cycle;
        test_exclusive;
        test_auto_cycle;
        test_timeout;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
